// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// Grants one operation at a time, registers operands, captures the result and holds it until the consumer takes it.
module alu_arbiter #(
    parameter logic FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_carry,
    output logic        busy,
    output logic [15:0] op_count,
    output logic [1:0]  dbg_state
);

    // Handshakes: a requester transfers when reqN_valid & reqN_ready; the result
    // transfers when rsp_valid & rsp_ready. Valid never waits on ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [3:0]  op_ctrl_q, op_ctrl_d;
    logic        last_grant_q, last_grant_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_carry_q, rsp_carry_d;
    logic [15:0] op_count_q, op_count_d;

    logic accept_window;
    logic tie_grant;
    logic grant_id;
    logic accept;

    // A new request may be taken while idle, or in the same cycle the pending result leaves.
    always_comb begin
        accept_window = rst_n && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
        tie_grant     = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        grant_id      = req0_valid ? (req1_valid ? tie_grant : 1'b0) : 1'b1;
        accept        = accept_window && (req0_valid || req1_valid);
        req0_ready    = accept && !grant_id;
        req1_ready    = accept && grant_id;
    end

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctrl_d    = op_ctrl_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
        op_count_d   = op_count_q;

        if (accept) begin
            op_a_d       = grant_id ? req1_a  : req0_a;
            op_b_d       = grant_id ? req1_b  : req0_b;
            op_ctrl_d    = grant_id ? req1_op : req0_op;
            last_grant_d = grant_id;
            rsp_id_d     = grant_id;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                rsp_data_d  = alu_result;
                rsp_zero_d  = alu_zero;
                rsp_carry_d = alu_carry;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = accept ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_ctrl_q    <= '0;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_ctrl_q    <= op_ctrl_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_a       = op_a_q;
    assign alu_b       = op_b_q;
    assign alu_control = op_ctrl_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_carry   = rsp_carry_q;
    assign busy        = (state_q != IDLE);
    assign op_count    = op_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances share one stimulus,
// each checked every cycle against a timestamp/queue model, plus directed literal checks.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;

    logic        u0_r0, u0_r1, u0_rv, u0_rid, u0_rz, u0_rc, u0_busy;
    logic [31:0] u0_aa, u0_ab, u0_rd, u0_res;
    logic [3:0]  u0_ctl;
    logic        u0_z, u0_c;
    logic [15:0] u0_cnt;
    logic [1:0]  u0_dbg;
    logic        u1_r0, u1_r1, u1_rv, u1_rid, u1_rz, u1_rc, u1_busy;
    logic [31:0] u1_aa, u1_ab, u1_rd, u1_res;
    logic [3:0]  u1_ctl;
    logic        u1_z, u1_c;
    logic [15:0] u1_cnt;
    logic [1:0]  u1_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    // Reference ALU: {zero, carry, result}; unknown opcodes give result 0, zero 1.
    function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        s = '0;
        r = '0;
        c = 1'b0;
        case (op)
            4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
            4'h8: begin r = a - b; c = (a < b); end
            4'h1: r = a ^ b;
            4'h7: r = (a < b) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {(r == 32'd0), c, r};
    endfunction

    assign {u0_z, u0_c, u0_res} = alu_f(u0_aa, u0_ab, u0_ctl);
    assign {u1_z, u1_c, u1_res} = alu_f(u1_aa, u1_ab, u1_ctl);

    alu_arbiter #(.FIXED_PRIO(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(u0_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(u0_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(u0_aa), .alu_b(u0_ab), .alu_control(u0_ctl),
        .alu_result(u0_res), .alu_zero(u0_z), .alu_carry(u0_c),
        .rsp_valid(u0_rv), .rsp_ready(rsp_ready), .rsp_id(u0_rid), .rsp_data(u0_rd),
        .rsp_zero(u0_rz), .rsp_carry(u0_rc), .busy(u0_busy), .op_count(u0_cnt), .dbg_state(u0_dbg)
    );

    alu_arbiter #(.FIXED_PRIO(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(u1_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(u1_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(u1_aa), .alu_b(u1_ab), .alu_control(u1_ctl),
        .alu_result(u1_res), .alu_zero(u1_z), .alu_carry(u1_c),
        .rsp_valid(u1_rv), .rsp_ready(rsp_ready), .rsp_id(u1_rid), .rsp_data(u1_rd),
        .rsp_zero(u1_rz), .rsp_carry(u1_rc), .busy(u1_busy), .op_count(u1_cnt), .dbg_state(u1_dbg)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state per instance: outstanding op, the cycle it was accepted, last tie winner, completions.
    bit          m_pend[2];
    int          m_acc[2];
    logic        m_last[2];
    logic [15:0] m_cnt[2];
    logic [34:0] exp_q0[$];
    logic [34:0] exp_q1[$];
    bit          fixed_prio[2] = '{1'b0, 1'b1};

    task automatic check_inst(input int k, input logic r0, input logic r1, input logic rv,
                              input logic bsy, input logic rid, input logic rz, input logic rc,
                              input logic [31:0] rd, input logic [15:0] cnt);
        logic        ev, win, g, e_r0, e_r1;
        logic [34:0] e;
        if (!rst_n) begin
            chk("rst_req0_ready", r0, 0);
            chk("rst_req1_ready", r1, 0);
            chk("rst_rsp_valid", rv, 0);
            chk("rst_busy", bsy, 0);
            chk("rst_op_count", cnt, 0);
            chk("rst_rsp_data", rd, 0);
            m_pend[k] = 0;
            m_cnt[k]  = '0;
            m_last[k] = 1'b1;
            if (k == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        // A result is presented from two cycles after acceptance until taken.
        ev  = m_pend[k] && (cyc >= m_acc[k] + 2);
        win = !m_pend[k] || (ev && rsp_ready);
        if (req0_valid && req1_valid) g = fixed_prio[k] ? 1'b0 : ~m_last[k];
        else                          g = !req0_valid;
        e_r0 = win && req0_valid && !g;
        e_r1 = win && req1_valid && g;
        chk("req0_ready", r0, e_r0);
        chk("req1_ready", r1, e_r1);
        chk("rsp_valid", rv, ev);
        chk("busy", bsy, m_pend[k]);
        chk("op_count", cnt, m_cnt[k]);
        if (ev) begin
            e = (k == 0) ? exp_q0[0] : exp_q1[0];
            chk("rsp_id", rid, e[34]);
            chk("rsp_zero", rz, e[33]);
            chk("rsp_carry", rc, e[32]);
            chk("rsp_data", rd, e[31:0]);
        end
        if (ev && rsp_ready) begin
            m_cnt[k]  = m_cnt[k] + 16'd1;
            m_pend[k] = 0;
            if (k == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        end
        if (e_r0 || e_r1) begin
            m_pend[k] = 1;
            m_acc[k]  = cyc;
            m_last[k] = g;
            e = g ? {1'b1, alu_f(req1_a, req1_b, req1_op)} : {1'b0, alu_f(req0_a, req0_b, req0_op)};
            if (k == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        check_inst(0, u0_r0, u0_r1, u0_rv, u0_busy, u0_rid, u0_rz, u0_rc, u0_rd, u0_cnt);
        check_inst(1, u1_r0, u1_r1, u1_rv, u1_busy, u1_rid, u1_rz, u1_rc, u1_rd, u1_cnt);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
    endtask

    task automatic reset_pulse();
        tick();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] ops[5];
        ops = '{4'h0, 4'h8, 4'h1, 4'h7, 4'h0};
        ops[4] = 4'($urandom_range(0, 15));
        return ops[$urandom_range(0, 4)];
    endfunction

    function automatic logic [31:0] rand_val();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    endfunction

    int grants[$];
    int n_r1_fixed;
    int n_r0_fixed;

    initial begin
        // Reset and the reference single operation 5 + 3.
        tick();
        tick();
        #2;
        chk("reset_busy", u0_busy, 0);
        chk("reset_rsp_valid", u0_rv, 0);
        chk("reset_alu_a", u0_aa, 0);
        rst_n = 1'b1;
        tick();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'h0; rsp_ready = 1'b1;
        #2 chk("single_req0_ready", u0_r0, 1);
        tick();
        req0_valid = 1'b0;
        #2 chk("single_alu_a", u0_aa, 5);
        tick();
        #2;
        chk("single_rsp_valid", u0_rv, 1);
        chk("single_rsp_id", u0_rid, 0);
        chk("single_rsp_data", u0_rd, 8);
        chk("single_rsp_zero", u0_rz, 0);
        chk("single_rsp_carry", u0_rc, 0);
        tick();
        #2 chk("single_op_count", u0_cnt, 1);

        // Ties after reset: round-robin alternates, fixed priority always picks 0.
        reset_pulse();
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd10; req0_b = 32'd20; req0_op = 4'h0;
        req1_a = 32'd7;  req1_b = 32'd7;  req1_op = 4'h8;
        grants.delete();
        n_r1_fixed = 0;
        n_r0_fixed = 0;
        for (int i = 0; i < 7; i++) begin
            #2;
            if (u0_r0) grants.push_back(0);
            if (u0_r1) grants.push_back(1);
            if (u1_r1) n_r1_fixed++;
            if (u1_r0) n_r0_fixed++;
            tick();
        end
        idle_inputs();
        tick();
        tick();
        #2;
        chk("tie_grant_count", grants.size(), 4);
        if (grants.size() == 4) begin
            chk("tie_grant0", grants[0], 0);
            chk("tie_grant1", grants[1], 1);
            chk("tie_grant2", grants[2], 0);
            chk("tie_grant3", grants[3], 1);
        end
        chk("tie_op_count", u0_cnt, 4);
        chk("fixed_req1_never", n_r1_fixed, 0);
        chk("fixed_req0_count", n_r0_fixed, 4);
        chk("fixed_op_count", u1_cnt, 4);

        // Backpressure on a borrowing subtract from requester 1.
        tick();
        req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd1; req1_op = 4'h8; rsp_ready = 1'b0;
        #2 chk("bp_req1_ready", u0_r1, 1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'h0;
        #2 chk("bp_exec_no_ready", u0_r0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            #2;
            chk("bp_rsp_valid", u0_rv, 1);
            chk("bp_rsp_data", u0_rd, 32'hFFFF_FFFF);
            chk("bp_rsp_carry", u0_rc, 1);
            chk("bp_rsp_id", u0_rid, 1);
            chk("bp_no_ready", u0_r0, 0);
        end
        tick();
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
        tick();
        #2;
        chk("bp_idle_busy", u0_busy, 0);
        chk("bp_idle_rsp_valid", u0_rv, 0);
        chk("bp_op_count", u0_cnt, 5);

        // Reset while a result is pending.
        tick();
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4; req0_op = 4'h0; rsp_ready = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick();
        #2 chk("rr_rsp_valid_before", u0_rv, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_rsp_valid_now", u0_rv, 0);
        chk("rr_op_count", u0_cnt, 0);
        chk("rr_req0_ready_in_reset", u0_r0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #2;
        chk("rr_first_tie_req0", u0_r0, 1);
        chk("rr_first_tie_req1", u0_r1, 0);
        tick();
        idle_inputs();
        tick();
        tick();
        tick();

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req0_a = rand_val(); req0_b = rand_val(); req0_op = rand_op();
            req1_a = rand_val(); req1_b = rand_val(); req1_op = rand_op();
        end
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) tick();

        // Counter wrap: preload near the top, then complete two operations.
        force u_dut0.op_count_q = 16'hFFFE;
        m_cnt[0] = 16'hFFFE;
        tick();
        release u_dut0.op_count_q;
        for (int n = 0; n < 2; n++) begin
            tick();
            req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'h0;
            tick();
            req0_valid = 1'b0;
            tick();
            tick();
        end
        #2 chk("wrap_op_count", u0_cnt, 16'h0000);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0; 0 = round-robin between requesters, 1 = requester 0 always wins ties.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 reqN_valid  in  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  out  1  requester N's operation accepted this cycle (valid & ready).
REQ-006 reqN_a, reqN_b  in  32 each  operands; reqN_op  in  4  ALU control code, forwarded unmodified.
REQ-007 alu_a, alu_b  out  32 each; alu_control  out  4  drive the shared ALU.
REQ-008 alu_result  in  32; alu_zero  in  1; alu_carry  in  1  combinational ALU outputs.
REQ-009 rsp_valid  out  1; rsp_ready  in  1  result handshake.
REQ-010 rsp_id  out  1  requester that issued the result; rsp_data  out  32; rsp_zero, rsp_carry  out  1 each.
REQ-011 busy  out  1  high when state is not IDLE.
REQ-012 op_count  out  16  completed-response counter.

Function
REQ-013 FSM states: IDLE, EXEC, RESP; exactly one active.
REQ-014 Accept window: IDLE, or RESP with rsp_ready=1; outside it both reqN_ready = 0.
REQ-015 In accept window with only reqN_valid high: reqN_ready=1 combinationally, grant N.
REQ-016 Both valid, FIXED_PRIO=0: grant the requester not equal to last_grant; FIXED_PRIO=1: grant requester 0.
REQ-017 At most one reqN_ready high in any cycle.
REQ-018 On acceptance: latch granted a, b, op into operand registers; last_grant <= granted id; rsp id register <= granted id; next state EXEC.
REQ-019 alu_a, alu_b, alu_control always equal the operand registers (no combinational path from reqN_* to ALU ports).
REQ-020 EXEC lasts exactly one cycle: at its end, rsp_data <= alu_result, rsp_zero <= alu_zero, rsp_carry <= alu_carry; next state RESP.
REQ-021 RESP: rsp_valid=1; rsp_data/zero/carry/id held stable until rsp_ready=1.
REQ-022 RESP with rsp_ready=1: op_count increments; next state EXEC if a request accepted that same cycle (REQ-014), else IDLE.
REQ-023 IDLE with no valid request: remain IDLE, no register change.
REQ-024 Latency: accept at cycle T -> rsp_valid high from cycle T+2; back-to-back throughput one result per 2 cycles with rsp_ready held high.
REQ-025 op_count wraps 0xFFFF -> 0x0000 without flag.
REQ-026 Requester deasserting valid without handshake is legal; no grant is recorded and last_grant unchanged.
REQ-027 Opcode values not recognized by the ALU are forwarded; response is whatever ALU returns (zero result, zero=1).
REQ-028 rsp_valid is a registered function of state only; never depends on rsp_ready.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, operand registers 0, alu_a/alu_b/alu_control 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_zero 0, rsp_carry 0, op_count 0, busy 0, last_grant 1 (so requester 0 wins first tie).
REQ-030 Reset asserted mid-operation (EXEC or RESP) discards the pending operation; no response delivered after reset release.
REQ-031 reqN_ready = 0 while rst_n low.

Verification
REQ-032 Single op: req0 a=5, b=3, op=0000 at T -> req0_ready=1 at T; rsp_valid at T+2 with rsp_id=0, rsp_data=8, zero=0, carry=0; op_count=1 after handshake.
REQ-033 Tie after reset (FIXED_PRIO=0): both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; results every 2 cycles; op_count=4 after four responses.
REQ-034 FIXED_PRIO=1, both valid held -> requester 0 granted every time, req1_ready never high.
REQ-035 Backpressure: req1 op=1000 a=0, b=1, rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_data=0xFFFFFFFF, carry=1 stable, no new ready; release -> handshake completes, state IDLE.
REQ-036 Reset in RESP: assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately, op_count=0; after release, first tie grants requester 0.
REQ-037 Wrap: preload via 65535 completed ops -> next completion gives op_count=0x0000.
